scan_mux: RTL and testbench
===========================

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of input channels (legal range 2..16).
REQ-002 Parameter WIDTH, default 8, SHALL set the bit width of each channel (legal range 1..32).
REQ-003 Parameter DWELL, default 4, SHALL set the cycles spent on each channel in scan mode (legal range 1..255).
REQ-004 Localparam CH_W SHALL equal max(1, clog2(N_CH)).
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 mode  input  1  SHALL select the operating mode: 0 = manual, 1 = scan.
REQ-008 sel  input  CH_W  SHALL give the manual-mode channel index.
REQ-009 hold  input  1  SHALL freeze the channel, the dwell count and the output when high.
REQ-010 din  input  N_CH*WIDTH  SHALL carry the packed channels, with channel k at bits [k*WIDTH +: WIDTH].
REQ-011 dout  output  WIDTH  SHALL be the registered selected data.
REQ-012 dout_valid  output  1  SHALL be high when dout holds data from a legal channel.
REQ-013 cur_ch  output  CH_W  SHALL be the index of the channel driving dout.
REQ-014 wrap  output  1  SHALL pulse for one cycle when scan mode advances from channel N_CH-1 to channel 0.

Function
REQ-015 The FSM SHALL have three states, MANUAL, SCAN and HOLD, and SHALL enter MANUAL on reset.
REQ-016 In MANUAL, dout SHALL equal din[sel] sampled on the previous edge (1-cycle latency), and cur_ch SHALL equal the registered sel.
REQ-017 In MANUAL, if sel >= N_CH, dout SHALL keep its previous value and dout_valid SHALL be 0 for that cycle.
REQ-018 On mode 0->1, SCAN SHALL start at the current cur_ch with the dwell counter at 0.
REQ-019 In SCAN, the dwell counter SHALL run from 0 to DWELL-1; at DWELL-1 the counter SHALL clear and cur_ch SHALL increment modulo N_CH.
REQ-020 In SCAN, dout SHALL register din[cur_ch] every cycle, and dout_valid SHALL be 1.
REQ-021 wrap SHALL assert in the cycle that cur_ch changes from N_CH-1 to 0, and never in MANUAL.
REQ-022 With DWELL = 1, cur_ch SHALL advance every cycle.
REQ-023 On mode 1->0, MANUAL SHALL take effect on the next edge, and the dwell counter SHALL clear.
REQ-024 hold = 1 SHALL move the FSM to HOLD from either mode, freezing dout, cur_ch, the counter and dout_valid; wrap SHALL be 0.
REQ-025 When hold falls, the FSM SHALL return to the state selected by the current mode; SCAN SHALL resume the frozen count and SHALL NOT restart it.
REQ-026 When hold and a mode change occur in the same cycle, hold SHALL have priority.

Reset
REQ-027 Asserting rst_n low at any time, including mid-dwell, SHALL immediately set dout = 0, dout_valid = 0, cur_ch = 0, wrap = 0, the counter = 0 and the state = MANUAL.
REQ-028 The first rising edge with rst_n high SHALL be the first functional edge.

Configuration
REQ-029 With SCAN_MUX_PARITY_EN defined, an output dout_par (1 bit) SHALL be added, carrying the registered even parity (XOR) of the selected data and aligned with dout.
REQ-030 Without SCAN_MUX_PARITY_EN, the dout_par port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-031 Package scan_mux_pkg SHALL hold the mode encoding constants, the FSM state enum (MANUAL, SCAN, HOLD) and the CH_W width function.
REQ-032 Sub-module scan_mux_dwell_cnt SHALL implement the dwell counter, with inputs clr and en and a terminal-count output tc.

Verification
REQ-033 Reset, then mode = 0, sel = 2, din ch2 = 8'hA5 -> one edge later dout = 8'hA5, dout_valid = 1, cur_ch = 2.
REQ-034 N_CH = 4, DWELL = 4, mode = 1 from cur_ch 0 -> cur_ch sequence 0,1,2,3,0, each held 4 cycles; wrap high for exactly 1 cycle at 3->0.
REQ-035 N_CH = 3, mode = 0, sel = 3 -> dout unchanged, dout_valid = 0; then sel = 1 -> dout = ch1 next cycle and dout_valid = 1.
REQ-036 Scan with hold high for 5 cycles at count 2 on channel 1 -> all outputs frozen; after release, 2 more cycles on channel 1, then channel 2.
REQ-037 rst_n pulsed low mid-dwell on channel 2 -> outputs cleared immediately, without waiting for a clock edge; scan restarts from channel 0 after release.
REQ-038 With SCAN_MUX_PARITY_EN defined, din ch0 = 8'h07 selected -> dout_par = 1 in the same cycle as dout.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared definitions for scan_mux: mode encoding, FSM states and channel-index width.
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2
    } state_e;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_mux_dwell_cnt.sv
// Dwell counter for scan_mux: counts 0..DWELL-1, tc flags the last count of a dwell.
module scan_mux_dwell_cnt #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel mux with manual select, timed round-robin scan and hold.
// Optional registered parity output dout_par when SCAN_MUX_PARITY_EN is defined.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [ch_width(N_CH)-1:0] sel,
    input  logic                      hold,
    input  logic [N_CH*WIDTH-1:0]     din,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_valid,
    output logic [ch_width(N_CH)-1:0] cur_ch,
    output logic                      wrap
`ifdef SCAN_MUX_PARITY_EN
    ,
    output logic                      dout_par
`endif
);

    localparam int unsigned CH_W = ch_width(N_CH);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [WIDTH-1:0]  dout_q, mux_data;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    logic              load;
    logic              cnt_clr, cnt_en, cnt_tc;

    scan_mux_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // The dwell only counts on edges where the FSM is already in SCAN, so entry
    // from MANUAL starts at count 0 and release from HOLD resumes the frozen count.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        load    = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (hold) begin
            state_d = HOLD;
        end else begin
            unique case (mode)
                MODE_MANUAL: begin
                    state_d = MANUAL;
                    cnt_clr = 1'b1;
                    if (32'(sel) < N_CH) begin
                        ch_d    = sel;
                        load    = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                MODE_SCAN: begin
                    state_d = SCAN;
                    load    = 1'b1;
                    valid_d = 1'b1;
                    if (state_q == SCAN) begin
                        cnt_en = 1'b1;
                        if (cnt_tc) begin
                            if (ch_q == CH_W'(N_CH - 1)) begin
                                ch_d   = '0;
                                wrap_d = 1'b1;
                            end else begin
                                ch_d = ch_q + CH_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        mux_data = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (ch_d == CH_W'(k)) begin
                mux_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MANUAL;
            ch_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            if (load) begin
                dout_q <= mux_data;
            end
        end
    end

`ifdef SCAN_MUX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^mux_data;
        end
    end

    assign dout_par = par_q;
`endif

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign cur_ch     = ch_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: two instances (4ch/dwell 4 and 3ch/dwell 1)
// against a behavioural model; parity checked when SCAN_MUX_PARITY_EN is defined.
module tb_scan_mux;

    typedef struct {
        int ch;
        int cnt;
        int dout;
        bit valid;
        bit wrap;
        bit scanning;
    } mdl_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        mode  = 1'b0;
    logic        hold  = 1'b0;
    logic [1:0]  sel   = 2'd0;
    logic [31:0] din   = '0;

    logic [7:0]  dout4, dout3;
    logic        v4, v3, w4, w3;
    logic [1:0]  ch4, ch3;
`ifdef SCAN_MUX_PARITY_EN
    logic        par4, par3;
`endif

    int   tests = 0;
    int   fails = 0;
    mdl_t m4, m3;

    scan_mux #(.N_CH(4), .WIDTH(8), .DWELL(4)) u4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .sel        (sel),
        .hold       (hold),
        .din        (din),
        .dout       (dout4),
        .dout_valid (v4),
        .cur_ch     (ch4),
        .wrap       (w4)
`ifdef SCAN_MUX_PARITY_EN
        ,
        .dout_par   (par4)
`endif
    );

    scan_mux #(.N_CH(3), .WIDTH(8), .DWELL(1)) u3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .sel        (sel),
        .hold       (hold),
        .din        (din[23:0]),
        .dout       (dout3),
        .dout_valid (v3),
        .cur_ch     (ch3),
        .wrap       (w3)
`ifdef SCAN_MUX_PARITY_EN
        ,
        .dout_par   (par3)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    // One clock edge of behaviour, expressed as the observable rules of the block.
    function automatic mdl_t step(mdl_t m, int n, int dw, bit md, bit hd, int s, logic [31:0] d);
        mdl_t r = m;
        r.wrap = 1'b0;
        if (hd) begin
            r.scanning = 1'b0;
        end else if (md) begin
            if (m.scanning) begin
                r.cnt = m.cnt + 1;
                if (r.cnt == dw) begin
                    r.cnt  = 0;
                    r.wrap = (m.ch == n - 1);
                    r.ch   = (m.ch + 1) % n;
                end
            end
            r.scanning = 1'b1;
            r.dout     = int'((d >> (8 * r.ch)) & 32'hFF);
            r.valid    = 1'b1;
        end else begin
            r.scanning = 1'b0;
            r.cnt      = 0;
            if (s < n) begin
                r.ch    = s;
                r.dout  = int'((d >> (8 * s)) & 32'hFF);
                r.valid = 1'b1;
            end else begin
                r.valid = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".u4.dout"},  32'(dout4), 32'(m4.dout));
        chk({ph, ".u4.valid"}, 32'(v4),    32'(m4.valid));
        chk({ph, ".u4.ch"},    32'(ch4),   32'(m4.ch));
        chk({ph, ".u4.wrap"},  32'(w4),    32'(m4.wrap));
        chk({ph, ".u3.dout"},  32'(dout3), 32'(m3.dout));
        chk({ph, ".u3.valid"}, 32'(v3),    32'(m3.valid));
        chk({ph, ".u3.ch"},    32'(ch3),   32'(m3.ch));
        chk({ph, ".u3.wrap"},  32'(w3),    32'(m3.wrap));
`ifdef SCAN_MUX_PARITY_EN
        chk({ph, ".u4.par"},   32'(par4),  32'(^m4.dout));
        chk({ph, ".u3.par"},   32'(par3),  32'(^m3.dout));
`endif
    endtask

    task automatic model_reset();
        m4 = '{default: 0};
        m3 = '{default: 0};
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m4 = step(m4, 4, 4, mode, hold, int'(sel), din);
            m3 = step(m3, 3, 1, mode, hold, int'(sel), {8'h00, din[23:0]});
        end
        #1;
        check_all(ph);
    endtask

    initial begin
        int wraps4;
        int guard;
        bit r1, r2;

        model_reset();

        // Asynchronous reset, checked before any clock edge sees it.
        #2 rst_n = 1'b0;
        #1 check_all("rst_async");
        tick("rst");
        tick("rst");
        rst_n = 1'b0;
        rst_n = 1'b1;

        // Manual select of channel 2, one-edge latency.
        mode = 1'b0;
        sel  = 2'd2;
        din  = {8'h3C, 8'hA5, 8'h5A, 8'h11};
        tick("r033");
        chk("r033.dout",  32'(dout4), 32'hA5);
        chk("r033.valid", 32'(v4),    32'd1);
        chk("r033.ch",    32'(ch4),   32'd2);

        // Illegal select on the 3-channel instance holds dout and drops valid.
        sel = 2'd1;
        tick("r035a");
        chk("r035a.u3.dout", 32'(dout3), 32'h5A);
        din = 32'h12345678;
        sel = 2'd3;
        tick("r035b");
        chk("r035b.u3.dout",  32'(dout3), 32'h5A);
        chk("r035b.u3.valid", 32'(v3),    32'd0);
        chk("r035b.u4.dout",  32'(dout4), 32'h12);
        sel = 2'd1;
        tick("r035c");
        chk("r035c.u3.dout",  32'(dout3), 32'h56);
        chk("r035c.u3.valid", 32'(v3),    32'd1);

        // Scan from channel 0: dwell 4 on u4, dwell 1 on u3.
        sel = 2'd0;
        tick("pre034");
        mode   = 1'b1;
        wraps4 = 0;
        for (int i = 0; i < 17; i++) begin
            din = $urandom;
            tick("r034");
            chk("r034.u4.ch",   32'(ch4), 32'((i / 4) % 4));
            chk("r034.u4.wrap", 32'(w4),  32'(i == 16));
            chk("r022.u3.ch",   32'(ch3), 32'(i % 3));
            chk("r022.u3.wrap", 32'(w3),  32'(i > 0 && (i % 3) == 0));
            wraps4 += int'(w4);
        end
        chk("r034.wrapcount", 32'(wraps4), 32'd1);

        // Hold at count 2 of channel 1, then resume the remaining dwell.
        guard = 0;
        while (!(m4.ch == 1 && m4.cnt == 2) && guard < 40) begin
            din = $urandom;
            tick("pre036");
            guard++;
        end
        r1 = (guard < 40);
        chk("r036.reach", 32'(r1), 32'd1);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = $urandom;
            tick("r036hold");
            chk("r036.hold.ch",   32'(ch4), 32'd1);
            chk("r036.hold.wrap", 32'(w4),  32'd0);
        end
        hold = 1'b0;
        tick("r036rel");
        chk("r036.rel1.ch", 32'(ch4), 32'd1);
        tick("r036rel");
        chk("r036.rel2.ch", 32'(ch4), 32'd1);
        tick("r036rel");
        chk("r036.rel3.ch", 32'(ch4), 32'd2);

        // Reset mid-dwell on channel 2, cleared without a clock edge.
        guard = 0;
        while (!(m4.ch == 2 && m4.cnt == 1) && guard < 40) begin
            tick("pre037");
            guard++;
        end
        r2 = (guard < 40);
        chk("r037.reach", 32'(r2), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("r037async");
        chk("r037.dout", 32'(dout4), 32'd0);
        chk("r037.ch",   32'(ch4),   32'd0);
        tick("r037rst");
        rst_n = 1'b1;
        din   = 32'hCAFE_F00D;
        tick("r037rel");
        chk("r037rel.ch",    32'(ch4),   32'd0);
        chk("r037rel.valid", 32'(v4),    32'd1);
        chk("r037rel.dout",  32'(dout4), 32'h0D);

`ifdef SCAN_MUX_PARITY_EN
        mode = 1'b0;
        sel  = 2'd0;
        din  = 32'h0000_0007;
        tick("r038");
        chk("r038.dout", 32'(dout4), 32'h07);
        chk("r038.par",  32'(par4),  32'd1);
`endif

        // Randomised traffic with mode runs, occasional hold and illegal selects.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            hold = ($urandom_range(0, 9) < 2);
            sel  = 2'($urandom_range(0, 3));
            din  = $urandom;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
